nonce_search_ctrl: RTL
======================

# nonce_search_ctrl

Sequencing controller for one nonce-search pass. It walks a nonce range, launches the SHA-256 core once per nonce, and pulses the target checker's enable after each hash completes. It reads the checker's registered verdict and stops on the first hit or when the range is exhausted. It sits between the host/config interface and the hash core and `sha256_target_checker` pair.

## Interface
Parameters:
- `NONCE_W`, 32, nonce width
- `HASH_W`, 256, hash/target width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin search; sampled only in IDLE or DONE
- `stop`  in  1  abort; sampled in every state
- `nonce_start`  in  NONCE_W  first nonce, latched on accepted start
- `nonce_end`  in  NONCE_W  last nonce (inclusive), latched on accepted start
- `target_in`  in  HASH_W  difficulty target, latched on accepted start
- `hash_start`  out  1  one-cycle launch pulse to hash core
- `hash_nonce`  out  NONCE_W  nonce under test; stable from ISSUE until the next ISSUE
- `hash_done`  in  1  one-cycle completion pulse from hash core
- `chk_enable`  out  1  one-cycle enable to target checker
- `chk_target`  out  HASH_W  latched target, driven to the checker
- `chk_valid`  in  1  registered checker verdict
- `busy`  out  1  high in ISSUE, WAIT, CHECK and EVAL
- `found`  out  1  search hit; held in DONE
- `exhausted`  out  1  range finished without a hit; held in DONE
- `golden_nonce`  out  NONCE_W  nonce that produced the hit
- `attempts`  out  32  nonces evaluated this pass (see Configuration)

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, EVAL, DONE.
- IDLE/DONE, `start`=1, `stop`=0 → latch range and target, clear `found`, `exhausted` and `attempts`, go to ISSUE.
- ISSUE → drive `hash_start`=1 for one cycle, go to WAIT.
- WAIT → on `hash_done`=1 go to CHECK. Otherwise remain in WAIT.
- CHECK → drive `chk_enable`=1 for one cycle, go to EVAL.
- EVAL → sample `chk_valid` and increment `attempts`:
  - `chk_valid`=1: `golden_nonce`←`hash_nonce`, `found`←1, go to DONE.
  - `hash_nonce`==`nonce_end`: `exhausted`←1, go to DONE.
  - Otherwise: `hash_nonce`←`hash_nonce`+1 (mod 2^NONCE_W), go to ISSUE.
- Wrap-around: if `nonce_end` < `nonce_start`, the walk passes through 2^NONCE_W−1 and 0 and terminates at `nonce_end`.
- Equal endpoints test exactly one nonce. The full range (`nonce_end` = `nonce_start`−1) tests 2^NONCE_W nonces.
- `stop`=1 in any state → IDLE next cycle; `found`, `exhausted` and `busy` cleared. `golden_nonce` and `attempts` are held.
- `start` and `stop` in the same cycle → `stop` wins.
- `start` while `busy` is ignored.
- `hash_done` outside WAIT is ignored, including a stale completion after an abort.
- `start` in DONE restarts a fresh pass immediately.

## Timing
- Reset (`reset_n`=0 at a clock edge): state IDLE. `hash_start`, `chk_enable`, `busy`, `found` and `exhausted` are 0. `hash_nonce`, `chk_target`, `golden_nonce` and `attempts` are 0.
- All outputs are registered. Reset asserted mid-search overrides everything, including a pending hit.
- `start` sampled at edge k → `hash_start` high in cycle k+1.
- `hash_done` high in cycle t → `chk_enable` high in t+1, `chk_valid` sampled in t+2 (EVAL).
- On a hit, `found` and `golden_nonce` are valid in t+3. On a miss, the next `hash_start` is in t+3.
- Per-nonce cost = core latency + 3 cycles.
- `chk_target` stays stable for the whole pass; it changes only on an accepted start.

## Configuration
- `NONCE_SEARCH_STATS_EN` defined: the 32-bit `attempts` counter is implemented. It saturates at 2^32−1.
- Not defined: the counter logic is removed and `attempts` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `mining_pkg`:
  - state enum `search_state_t`
  - default widths `NONCE_W_DEF`=32 and `HASH_W_DEF`=256
- One sub-module, `nonce_range_counter`, is natural:
  - loads start/end, increments mod 2^NONCE_W, flags `last` when the count equals end
  - the FSM stays in the top level

## Test plan
- Range 0x10..0x13, hash core model with latency 5, checker hits on nonce 0x12 → `found`=1, `golden_nonce`=0x12, `attempts`=3, `exhausted`=0.
- Range 0x20..0x22, no hit → `exhausted`=1, `found`=0, `attempts`=3, exactly 3 `hash_start` pulses.
- Range 0xFFFFFFFE..0x00000001, no hit → nonces issued in order FFFFFFFE, FFFFFFFF, 0, 1, then `exhausted`=1.
- `start`=1 at range 5..5, hit → single `hash_start` with `hash_nonce`=5; `found` asserted exactly 3 cycles after `hash_done`.
- `stop` asserted in WAIT, then a stale `hash_done` two cycles later → IDLE, `busy`=0, no `chk_enable` pulse, `found`=0.
- `reset_n`=0 during EVAL of a hit cycle → all outputs 0 next cycle; a subsequent `start` runs a fresh pass from `nonce_start`.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared types and default widths for the nonce-search datapath.
package mining_pkg;

    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF  = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_EVAL,
        S_DONE
    } search_state_t;

endpackage

// File: rtl/nonce_range_counter.sv
// Nonce walker: loads start/end, steps mod 2^NONCE_W, flags the inclusive end.
module nonce_range_counter #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               advance,
    input  logic [NONCE_W-1:0] start_val,
    input  logic [NONCE_W-1:0] end_val,
    output logic [NONCE_W-1:0] count,
    output logic               last
);

    logic [NONCE_W-1:0] end_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            end_q <= '0;
        end else if (load) begin
            count <= start_val;
            end_q <= end_val;
        end else if (advance) begin
            count <= count + 1'b1;
        end
    end

    // End is inclusive, so a full-range walk (end = start-1) covers every nonce.
    assign last = (count == end_q);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce-search pass sequencer between host config and the hash core / target checker.
// Optional attempts counter enabled by defining NONCE_SEARCH_STATS_EN.
module nonce_search_ctrl
    import mining_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int HASH_W  = HASH_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [HASH_W-1:0]  target_in,
    output logic               hash_start,
    output logic [NONCE_W-1:0] hash_nonce,
    input  logic               hash_done,
    output logic               chk_enable,
    output logic [HASH_W-1:0]  chk_target,
    input  logic               chk_valid,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic [31:0]        attempts
);

    // state   | meaning
    // IDLE    | waiting for start
    // ISSUE   | hash_start pulse for current nonce
    // WAIT    | waiting for hash core completion
    // CHECK   | chk_enable pulse to target checker
    // EVAL    | sample checker verdict, advance or finish
    // DONE    | found/exhausted held until next start or stop

    search_state_t state, state_next;

    logic accept;
    logic hit;
    logic range_end;
    logic advance;
    logic last;

    nonce_range_counter #(.NONCE_W(NONCE_W)) u_range (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept),
        .advance   (advance),
        .start_val (nonce_start),
        .end_val   (nonce_end),
        .count     (hash_nonce),
        .last      (last)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        hit        = 1'b0;
        range_end  = 1'b0;
        advance    = 1'b0;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        accept     = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
                S_ISSUE: state_next = S_WAIT;
                S_WAIT: begin
                    if (hash_done) state_next = S_CHECK;
                end
                S_CHECK: state_next = S_EVAL;
                S_EVAL: begin
                    if (chk_valid) begin
                        hit        = 1'b1;
                        state_next = S_DONE;
                    end else if (last) begin
                        range_end  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Pulses and flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            hash_start   <= 1'b0;
            chk_enable   <= 1'b0;
            busy         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            chk_target   <= '0;
            golden_nonce <= '0;
        end else begin
            state      <= state_next;
            hash_start <= (state_next == S_ISSUE);
            chk_enable <= (state_next == S_CHECK);
            busy       <= (state_next == S_ISSUE) || (state_next == S_WAIT) ||
                          (state_next == S_CHECK) || (state_next == S_EVAL);
            if (stop || accept) begin
                found     <= 1'b0;
                exhausted <= 1'b0;
            end else begin
                if (hit)       found     <= 1'b1;
                if (range_end) exhausted <= 1'b1;
            end
            if (accept) chk_target   <= target_in;
            if (hit)    golden_nonce <= hash_nonce;
        end
    end

`ifdef NONCE_SEARCH_STATS_EN
    logic [31:0] attempts_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            attempts_q <= '0;
        end else if (accept) begin
            attempts_q <= '0;
        end else if (state == S_EVAL && !stop && attempts_q != 32'hFFFF_FFFF) begin
            attempts_q <= attempts_q + 32'd1;
        end
    end

    assign attempts = attempts_q;
`else
    assign attempts = 32'd0;
`endif

endmodule
